// File: rtl/jtag_tap_responder_if.sv
// JTAG pin and observation bundle between a JTAG controller (master) and the
// target-side TAP responder (slave).
interface jtag_tap_responder_if #(
    parameter int INSTRUCTION_WIDTH = 5,
    parameter int TEST_VECTOR_WIDTH = 32
);
    logic                         Tms;
    logic                         Tdi;
    logic                         Tdo;
    logic                         TdoEnable;
    logic [3:0]                   tapState;
    logic [INSTRUCTION_WIDTH-1:0] currentInstruction;
    logic [TEST_VECTOR_WIDTH-1:0] capturedVector;
    logic                         vectorValid;

    modport master (
        output Tms, Tdi,
        input  Tdo, TdoEnable, tapState, currentInstruction, capturedVector, vectorValid
    );

    modport slave (
        input  Tms, Tdi,
        output Tdo, TdoEnable, tapState, currentInstruction, capturedVector, vectorValid
    );
endinterface

// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP responder: 16-state TAP controller, instruction
// register, bypass register and a test-vector register that returns the
// previously held vector while capturing a new one. Tck is modelled by clk.
//
// Optional feature: define JTAG_IDCODE_EN to add a 32-bit IDCODE register
// selected by opcode 2; without it opcode 2 decodes as BYPASS.
//
// state  | meaning
// TLR    | Test-Logic-Reset, instruction forced to BYPASS
// RTI    | Run-Test/Idle
// SEL_DR | Select-DR-Scan
// CAP_DR | Capture-DR, load selected data register
// SH_DR  | Shift-DR, Tdi in / Tdo out LSB first
// EX1_DR | Exit1-DR
// PAU_DR | Pause-DR, shift register held
// EX2_DR | Exit2-DR
// UPD_DR | Update-DR, VECTOR latches capturedVector
// SEL_IR | Select-IR-Scan
// CAP_IR | Capture-IR, load 0..01
// SH_IR  | Shift-IR
// EX1_IR | Exit1-IR
// PAU_IR | Pause-IR
// EX2_IR | Exit2-IR
// UPD_IR | Update-IR, latch currentInstruction
module jtag_tap_responder #(
    parameter int          INSTRUCTION_WIDTH = 5,
    parameter int          TEST_VECTOR_WIDTH = 32,
    parameter logic [31:0] IDCODE_VALUE      = 32'h1234_5679
) (
    input  logic                 clk,
    input  logic                 reset,
    jtag_tap_responder_if.slave  jtag
);
    localparam int IW  = INSTRUCTION_WIDTH;
    localparam int TVW = TEST_VECTOR_WIDTH;

    if (!(IW inside {3, 4, 5}) || !(TVW inside {8, 16, 24, 32}) || (IDCODE_VALUE[0] != 1'b1)) begin : g_param_check
        $error("jtag_tap_responder: illegal parameter value");
    end

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

    tap_state_e     state_q, state_d;
    logic [IW-1:0]  ir_shift_q;
    logic [IW-1:0]  cur_instr_q;
    logic           bypass_q;
    logic [TVW-1:0] data_shift_q;
    logic [TVW-1:0] captured_q;
    logic           valid_q;
    logic           sel_vector;
    logic           sel_idcode;
    logic           idcode_tdo;
    logic           tdo_d;

    // Any opcode other than VECTOR (and IDCODE when present) falls back to BYPASS.
    assign sel_vector = (cur_instr_q == IW'(1));

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_shift_q;

    assign sel_idcode = (cur_instr_q == IW'(2));
    assign idcode_tdo = idcode_shift_q[0];

    // IDCODE register: always 32 bits regardless of the test-vector width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcode_shift_q <= '0;
        end else if (sel_idcode) begin
            if (state_q == CAP_DR) begin
                idcode_shift_q <= IDCODE_VALUE;
            end else if (state_q == SH_DR) begin
                idcode_shift_q <= {jtag.Tdi, idcode_shift_q[31:1]};
            end
        end
    end
`else
    assign sel_idcode = 1'b0;
    assign idcode_tdo = 1'b0;
`endif

    // TAP state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS transition graph.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = jtag.Tms ? TLR    : RTI;
            RTI:    state_d = jtag.Tms ? SEL_DR : RTI;
            SEL_DR: state_d = jtag.Tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = jtag.Tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = jtag.Tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = jtag.Tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = jtag.Tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = jtag.Tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = jtag.Tms ? SEL_DR : RTI;
            SEL_IR: state_d = jtag.Tms ? TLR    : CAP_IR;
            CAP_IR: state_d = jtag.Tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = jtag.Tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = jtag.Tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = jtag.Tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = jtag.Tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = jtag.Tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Instruction, bypass and test-vector registers; Pause/Exit states hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_shift_q   <= '0;
            cur_instr_q  <= '0;
            bypass_q     <= 1'b0;
            data_shift_q <= '0;
            captured_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                TLR: cur_instr_q <= '0;
                CAP_IR: ir_shift_q <= {{(IW-2){1'b0}}, 2'b01};
                SH_IR: ir_shift_q <= {jtag.Tdi, ir_shift_q[IW-1:1]};
                UPD_IR: cur_instr_q <= ir_shift_q;
                CAP_DR: begin
                    if (sel_vector) begin
                        data_shift_q <= captured_q;
                    end else if (!sel_idcode) begin
                        bypass_q <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_vector) begin
                        data_shift_q <= {jtag.Tdi, data_shift_q[TVW-1:1]};
                    end else if (!sel_idcode) begin
                        bypass_q <= jtag.Tdi;
                    end
                end
                UPD_DR: begin
                    if (sel_vector) begin
                        captured_q <= data_shift_q;
                        valid_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tdo mux: LSB of the register currently being shifted, else 0.
    always_comb begin
        tdo_d = 1'b0;
        if (state_q == SH_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_vector) begin
                tdo_d = data_shift_q[0];
            end else if (sel_idcode) begin
                tdo_d = idcode_tdo;
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    assign jtag.Tdo                = tdo_d;
    assign jtag.TdoEnable          = (state_q == SH_IR) || (state_q == SH_DR);
    assign jtag.tapState           = state_q;
    assign jtag.currentInstruction = cur_instr_q;
    assign jtag.capturedVector     = captured_q;
    assign jtag.vectorValid        = valid_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: expected Tdo bits are queued as each
// scan is set up and popped bit by bit while the DUT shifts.
module tb_jtag_tap_responder;
    localparam int          IW  = 5;
    localparam int          TVW = 32;
    localparam logic [31:0] IDV = 32'h1234_5679;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jtag_tap_responder_if #(.INSTRUCTION_WIDTH(IW), .TEST_VECTOR_WIDTH(TVW)) jif ();

    jtag_tap_responder #(
        .INSTRUCTION_WIDTH(IW),
        .TEST_VECTOR_WIDTH(TVW),
        .IDCODE_VALUE(IDV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .jtag  (jif)
    );

    int       n_checks = 0;
    int       n_errors = 0;
    logic     exp_q[$];
    logic [TVW-1:0] model_vec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Tck: drive inputs, take the rising edge, settle.
    task automatic cyc(input logic tms, input logic tdi);
        jif.Tms = tms;
        jif.Tdi = tdi;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        logic e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk(tag, 64'(jif.Tdo), 64'(e));
    endtask

    // Vector register: previous vector comes out first, then the overflow of new bits.
    task automatic push_vec(input logic [TVW-1:0] prev, input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i < TVW ? prev[i] : d[i-TVW]);
    endtask

    task automatic push_byp(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i == 0 ? 1'b0 : d[i-1]);
    endtask

    task automatic push_id(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i < 32 ? IDV[i] : d[i-32]);
    endtask

    function automatic logic [TVW-1:0] vec_after(input logic [TVW-1:0] prev, input logic [63:0] d, input int n);
        logic [TVW-1:0] r;
        for (int j = 0; j < TVW; j++) r[j] = (j + n < TVW) ? prev[j+n] : d[j+n-TVW];
        return r;
    endfunction

    // RTI -> IR scan of v -> RTI.
    task automatic scan_ir(input logic [IW-1:0] v);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("st_sel_ir", 64'(jif.tapState), 64'd9);
        cyc(1'b0, 1'b0);
        chk("st_cap_ir", 64'(jif.tapState), 64'd10);
        cyc(1'b0, 1'b0);
        chk("st_sh_ir", 64'(jif.tapState), 64'd11);
        for (int i = 0; i < IW; i++) exp_q.push_back(i == 0);
        for (int i = 0; i < IW; i++) begin
            pop_chk("ir_tdo");
            cyc(i == IW - 1, v[i]);
        end
        chk("st_ex1_ir", 64'(jif.tapState), 64'd12);
        cyc(1'b1, 1'b0);
        chk("st_upd_ir", 64'(jif.tapState), 64'd15);
        cyc(1'b0, 1'b0);
        chk("cur_instr", 64'(jif.currentInstruction), 64'(v));
        chk("st_rti", 64'(jif.tapState), 64'd1);
    endtask

    // RTI -> DR scan of n bits (optional pause after pause_at bits) -> RTI.
    task automatic scan_dr(input int n, input logic [63:0] d, input int pause_at);
        cyc(1'b1, 1'b0);
        chk("st_sel_dr", 64'(jif.tapState), 64'd2);
        cyc(1'b0, 1'b0);
        chk("st_cap_dr", 64'(jif.tapState), 64'd3);
        cyc(1'b0, 1'b0);
        chk("st_sh_dr", 64'(jif.tapState), 64'd4);
        chk("tdo_en_sh", 64'(jif.TdoEnable), 64'd1);
        for (int i = 0; i < n; i++) begin
            pop_chk("dr_tdo");
            if (pause_at != 0 && i == pause_at - 1 && i != n - 1) begin
                cyc(1'b1, d[i]);
                chk("st_ex1_dr", 64'(jif.tapState), 64'd5);
                cyc(1'b0, 1'b0);
                cyc(1'b0, 1'b1);
                chk("st_pau_dr", 64'(jif.tapState), 64'd6);
                chk("tdo_en_pau", 64'(jif.TdoEnable), 64'd0);
                chk("tdo_pau", 64'(jif.Tdo), 64'd0);
                cyc(1'b1, 1'b1);
                chk("st_ex2_dr", 64'(jif.tapState), 64'd7);
                cyc(1'b0, 1'b1);
            end else begin
                cyc(i == n - 1, d[i]);
            end
        end
        cyc(1'b1, 1'b0);
        chk("st_upd_dr", 64'(jif.tapState), 64'd8);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        reset   = 1'b0;
        jif.Tms = 1'b1;
        jif.Tdi = 1'b0;
        model_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(jif.tapState), 64'd0);
        chk("rst_instr", 64'(jif.currentInstruction), 64'd0);
        chk("rst_vec", 64'(jif.capturedVector), 64'd0);
        chk("rst_valid", 64'(jif.vectorValid), 64'd0);
        chk("rst_tdo_en", 64'(jif.TdoEnable), 64'd0);
        chk("rst_tdo", 64'(jif.Tdo), 64'd0);
        reset = 1'b1;

        repeat (5) cyc(1'b1, 1'b0);
        chk("tlr_state", 64'(jif.tapState), 64'd0);
        chk("tlr_instr", 64'(jif.currentInstruction), 64'd0);
        cyc(1'b0, 1'b0);
        chk("rti_state", 64'(jif.tapState), 64'd1);

        // VECTOR load, then read back while loading a second value through a pause.
        scan_ir(5'd1);
        d = 64'hA5A5_0F0F;
        push_vec(model_vec, d, 32);
        scan_dr(32, d, 0);
        chk("vec_valid_1", 64'(jif.vectorValid), 64'd1);
        chk("vec_cap_1", 64'(jif.capturedVector), 64'hA5A5_0F0F);
        model_vec = vec_after(model_vec, d, 32);
        cyc(1'b0, 1'b0);
        chk("vec_valid_0", 64'(jif.vectorValid), 64'd0);

        d = 64'h1357_9BDF;
        push_vec(model_vec, d, 32);
        scan_dr(32, d, 13);
        chk("vec_valid_2", 64'(jif.vectorValid), 64'd1);
        model_vec = vec_after(model_vec, d, 32);
        chk("vec_cap_2", 64'(jif.capturedVector), 64'(model_vec));

        // Under-shift keeps captured upper bits; over-shift drops overflow.
        d = 64'hCC;
        push_vec(model_vec, d, 8);
        scan_dr(8, d, 0);
        model_vec = vec_after(model_vec, d, 8);
        chk("vec_under", 64'(jif.capturedVector), 64'(model_vec));
        d = 64'h9C_3E5A_7B11;
        push_vec(model_vec, d, 40);
        scan_dr(40, d, 0);
        model_vec = vec_after(model_vec, d, 40);
        chk("vec_over", 64'(jif.capturedVector), 64'(model_vec));

        // BYPASS: one-bit delay, vector untouched.
        scan_ir(5'd0);
        d = 64'b1101;
        push_byp(d, 4);
        scan_dr(4, d, 0);
        chk("byp_valid", 64'(jif.vectorValid), 64'd0);
        chk("byp_vec", 64'(jif.capturedVector), 64'(model_vec));

        // Opcode 2: IDCODE when enabled, otherwise BYPASS.
        scan_ir(5'd2);
        d = 64'h0000_0000_F00D_C0DE;
`ifdef JTAG_IDCODE_EN
        push_id(d, 32);
`else
        push_byp(d, 32);
`endif
        scan_dr(32, d, 0);
        chk("id_vec", 64'(jif.capturedVector), 64'(model_vec));

        // All-ones opcode decodes as BYPASS.
        scan_ir(5'h1F);
        d = 64'b101100;
        push_byp(d, 6);
        scan_dr(6, d, 3);
        chk("ones_vec", 64'(jif.capturedVector), 64'(model_vec));

        // Reset mid-shift aborts everything at once.
        scan_ir(5'd1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom));
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 64'(jif.tapState), 64'd0);
        chk("mid_rst_vec", 64'(jif.capturedVector), 64'd0);
        chk("mid_rst_instr", 64'(jif.currentInstruction), 64'd0);
        chk("mid_rst_tdo_en", 64'(jif.TdoEnable), 64'd0);
        model_vec = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        chk("post_rst_rti", 64'(jif.tapState), 64'd1);
        scan_ir(5'd1);
        d = 64'hC0DE_1234;
        push_vec(model_vec, d, 32);
        scan_dr(32, d, 0);
        model_vec = vec_after(model_vec, d, 32);
        chk("post_rst_valid", 64'(jif.vectorValid), 64'd1);
        chk("post_rst_vec", 64'(jif.capturedVector), 64'(model_vec));

        // Five Tms=1 from Pause-DR reach TLR; the instruction clears on the next TLR edge.
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("st_pau_dr_2", 64'(jif.tapState), 64'd6);
        repeat (5) cyc(1'b1, 1'b0);
        chk("five_ones_tlr", 64'(jif.tapState), 64'd0);
        cyc(1'b1, 1'b0);
        chk("tlr_clears_ir", 64'(jif.currentInstruction), 64'd0);
        chk("tlr_keeps_vec", 64'(jif.capturedVector), 64'(model_vec));

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
